// File: rtl/floor_request_unit.sv
// Elevator call-button front end: synchronise, debounce and latch floor calls, then offer SCAN-ordered targets.
// Optional PRESS_CANCEL_EN: re-pressing a pending floor cancels it, except the floor currently offered or being served.
module floor_request_unit #(
    parameter int NUM_FLOORS      = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [3:0]            cur_floor,
    input  logic                  arrive,
    output logic                  req_valid,
    output logic [3:0]            req_floor,
    input  logic                  req_ready,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

    state_t                state, state_next;
    logic [NUM_FLOORS-1:0] btn_p0, btn_p1, deb_p2;
    logic [CNT_W-1:0]      cnt_p2 [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] rise, clr, cancel;
    logic                  up_hit, dn_hit, has_target, tdir;
    logic [3:0]            up_floor, dn_floor, target;
    logic                  valid_next, dir_next;
    logic [3:0]            floor_next;

    // Stage p0/p1: two-flop synchroniser; stage p2: per-button debouncer
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_p0 <= '0;
            btn_p1 <= '0;
            deb_p2 <= '0;
            for (int k = 0; k < NUM_FLOORS; k++) cnt_p2[k] <= '0;
        end else begin
            btn_p0 <= btn;
            btn_p1 <= btn_p0;
            for (int k = 0; k < NUM_FLOORS; k++) begin
                if (btn_p1[k] == deb_p2[k]) begin
                    cnt_p2[k] <= '0;
                end else if (cnt_p2[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_p2[k] <= '0;
                    deb_p2[k] <= ~deb_p2[k];
                end else begin
                    cnt_p2[k] <= cnt_p2[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rise   = '0;
        clr    = '0;
        cancel = '0;
        for (int k = 0; k < NUM_FLOORS; k++) begin
            // Debounced rising edge is the cycle the counter is about to flip the level high
            rise[k] = btn_p1[k] & ~deb_p2[k] & (cnt_p2[k] == CNT_W'(DEBOUNCE_CYCLES - 1));
            clr[k]  = arrive & (cur_floor == 4'(k + 1));
`ifdef PRESS_CANCEL_EN
            cancel[k] = rise[k] & pending[k] &
                        ~((state != IDLE) && (req_floor == 4'(k + 1)));
`endif
        end
    end

    // Request latch: clear from arrive always beats a same-cycle set
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= ((pending | rise) & ~cancel) & ~clr;
        end
    end

    always_comb begin
        up_hit   = 1'b0;
        up_floor = 4'd0;
        dn_hit   = 1'b0;
        dn_floor = 4'd0;
        // Descending scan leaves the lowest match; ascending leaves the highest
        for (int k = NUM_FLOORS - 1; k >= 0; k--) begin
            if (pending[k] && (4'(k + 1) >= cur_floor)) begin
                up_hit   = 1'b1;
                up_floor = 4'(k + 1);
            end
        end
        for (int k = 0; k < NUM_FLOORS; k++) begin
            if (pending[k] && (4'(k + 1) <= cur_floor)) begin
                dn_hit   = 1'b1;
                dn_floor = 4'(k + 1);
            end
        end
        has_target = |pending;
        if (dir) begin
            tdir   = up_hit;
            target = up_hit ? up_floor : dn_floor;
        end else begin
            tdir   = ~dn_hit;
            target = dn_hit ? dn_floor : up_floor;
        end
    end

    always_comb begin
        state_next = state;
        valid_next = req_valid;
        floor_next = req_floor;
        dir_next   = dir;
        case (state)
            IDLE: begin
                if (has_target) begin
                    floor_next = target;
                    valid_next = 1'b1;
                    dir_next   = tdir;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (req_ready) begin
                    valid_next = 1'b0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Arrivals elsewhere are intermediate stops and keep us waiting
                if (arrive && (cur_floor == req_floor)) state_next = IDLE;
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_valid <= 1'b0;
            req_floor <= 4'd0;
            dir       <= 1'b1;
        end else begin
            state     <= state_next;
            req_valid <= valid_next;
            req_floor <= floor_next;
            dir       <= dir_next;
        end
    end

endmodule

// File: tb/tb_floor_request_unit.sv
// Directed and randomized bench for floor_request_unit; SCAN service order checked against a floor-list model.
// Optional PRESS_CANCEL_EN selects the toggle-cancel expectations.
module tb_floor_request_unit;

    localparam int NF = 4;
    localparam int DB = 16;

    logic          clk = 1'b0;
    logic          reset, arrive, req_ready, req_valid, dir;
    logic [NF-1:0] btn, pending;
    logic [3:0]    cur_floor, req_floor;
    int            checks = 0, passes = 0, fails = 0;

    always #5 clk = ~clk;

    floor_request_unit #(.NUM_FLOORS(NF), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .btn(btn), .cur_floor(cur_floor), .arrive(arrive),
        .req_valid(req_valid), .req_floor(req_floor), .req_ready(req_ready),
        .pending(pending), .dir(dir)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [NF-1:0] m);
        tick(24);
        btn = m;
        tick(DB + 2);
        btn = '0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 8 && req_valid !== 1'b1; i++) tick(1);
        check(tag, req_valid, 1);
    endtask

    task automatic accept();
        req_ready = 1'b1;
        tick(1);
        req_ready = 1'b0;
    endtask

    task automatic arrive_at(input logic [3:0] f);
        cur_floor = f;
        arrive = 1'b1;
        tick(1);
        arrive = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn = '0;
        arrive = 1'b0;
        req_ready = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    // SCAN rule over a list of requested floor numbers
    function automatic int pick(input bit [NF-1:0] p, input int cur, input bit d, output bit d_out);
        int up = 0, down = 0;
        for (int f = NF; f >= 1; f--) if (p[f-1] && f >= cur) up = f;
        for (int f = 1; f <= NF; f++) if (p[f-1] && f <= cur) down = f;
        if (d) begin
            d_out = (up != 0);
            return (up != 0) ? up : down;
        end
        d_out = (down == 0);
        return (down != 0) ? down : up;
    endfunction

    initial begin
        bit [NF-1:0] pend;
        bit          mdir, ndir;
        int          tgt, f, hold;

        cur_floor = 4'd1;
        do_reset();
        check("reset_pending", pending, 0);
        check("reset_valid", req_valid, 0);
        check("reset_floor", req_floor, 0);
        check("reset_dir", dir, 1);

        // Basic press, 18-cycle latency, offer and accept
        req_ready = 1'b1;
        btn = 4'b0100;
        tick(DB + 1);
        check("t1_pending_early", pending, 4'b0000);
        tick(1);
        check("t1_pending_set", pending, 4'b0100);
        check("t1_valid_lag", req_valid, 0);
        tick(1);
        check("t1_valid", req_valid, 1);
        check("t1_floor", req_floor, 3);
        check("t1_dir", dir, 1);
        tick(1);
        check("t1_accepted", req_valid, 0);
        tick(10);
        btn = '0;
        req_ready = 1'b0;
        arrive_at(4'd3);
        check("t1_served", pending, 0);

        // Short glitch rejected
        btn = 4'b0010;
        tick(10);
        btn = '0;
        tick(30);
        check("t2_pending", pending, 0);
        check("t2_valid", req_valid, 0);

        // Up sweep then reversal
        cur_floor = 4'd2;
        press(4'b1001);
        check("t3_pending", pending, 4'b1001);
        tick(1);
        check("t3_floor_up", req_floor, 4);
        check("t3_dir_up", dir, 1);
        accept();
        check("t3_accept", req_valid, 0);
        arrive_at(4'd4);
        check("t3_pending_after", pending, 4'b0001);
        tick(1);
        check("t3_valid_down", req_valid, 1);
        check("t3_floor_down", req_floor, 1);
        check("t3_dir_down", dir, 0);
        accept();
        arrive_at(4'd1);
        check("t3_empty", pending, 0);

        // Open offer not retargeted by a closer call
        press(4'b0100);
        tick(1);
        check("t4_floor", req_floor, 3);
        check("t4_dir", dir, 1);
        press(4'b0010);
        check("t4_pending", pending, 4'b0110);
        check("t4_hold_floor", req_floor, 3);
        check("t4_hold_valid", req_valid, 1);
        accept();
        arrive_at(4'd3);
        tick(1);
        check("t4_next_floor", req_floor, 2);
        check("t4_next_dir", dir, 0);
        accept();
        arrive_at(4'd2);
        check("t4_empty", pending, 0);

        // Set and clear in the same cycle, then out-of-range arrive
        tick(24);
        btn = 4'b0010;
        tick(DB + 1);
        arrive = 1'b1;
        tick(1);
        arrive = 1'b0;
        btn = '0;
        check("t5_clear_wins", pending, 0);
        tick(1);
        check("t5_no_offer", req_valid, 0);
        press(4'b1000);
        tick(1);
        check("t5_floor4", req_floor, 4);
        arrive_at(4'd0);
        check("t5_bad_arrive", pending, 4'b1000);
        check("t5_offer_kept", req_valid, 1);

        // Reset in BUSY
        press(4'b0010);
        accept();
        check("t6_busy_pending", pending, 4'b1010);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_pending", pending, 0);
        check("t6_valid", req_valid, 0);
        check("t6_dir", dir, 1);
        check("t6_floor", req_floor, 0);
        tick(1);
        check("t6_idle", req_valid, 0);

        // Re-press of a pending floor
        cur_floor = 4'd1;
        press(4'b1010);
        tick(1);
        check("t6_offer2", req_floor, 2);
        press(4'b1000);
`ifdef PRESS_CANCEL_EN
        check("t6_cancel", pending, 4'b0010);
        press(4'b0010);
        check("t6_target_kept", pending, 4'b0010);
`else
        check("t6_repress", pending, 4'b1010);
`endif

        // Randomized SCAN service sessions
        for (int s = 0; s < 10; s++) begin
            cur_floor = 4'($urandom_range(1, NF));
            do_reset();
            pend = NF'($urandom_range(1, (1 << NF) - 1));
            mdir = 1'b1;
            press(pend);
            check("rnd_pending", pending, pend);
            for (int it = 0; it < NF && pend != 0; it++) begin
                wait_valid("rnd_valid");
                tgt = pick(pend, int'(cur_floor), mdir, ndir);
                mdir = ndir;
                check("rnd_floor", req_floor, tgt);
                check("rnd_dir", dir, mdir);
                hold = $urandom_range(0, 3);
                tick(hold);
                check("rnd_hold", req_floor, tgt);
                accept();
                check("rnd_accept", req_valid, 0);
                f = $urandom_range(1, NF);
                if ($urandom_range(0, 1) == 1 && f != tgt) begin
                    arrive_at(4'(f));
                    pend[f-1] = 1'b0;
                    tick(1);
                    check("rnd_stop_busy", req_valid, 0);
                end
                arrive_at(4'(tgt));
                pend[tgt-1] = 1'b0;
                check("rnd_served", pending, pend);
            end
            tick(3);
            check("rnd_idle", req_valid, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
